pc_branch_sequencer: RTL

//  Owns the program counter. Consumes the resolved branch (target sum + zero flag) from the EX-stage

---
 rtl/cpu_pkg.sv | 17 +
 rtl/pc_branch_sequencer.sv | 122 ++++++++++++
 2 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the program-counter / branch sequencer.
//   seq_state_t : sequencer FSM states
//   RESET_PC    : default PC loaded on reset
//   INSTR_BYTES : default sequential fetch increment (also the target alignment)
package cpu_pkg;

  typedef enum logic [1:0] {
    BOOT     = 2'd0,
    RUN      = 2'd1,
    REDIRECT = 2'd2,
    FAULT    = 2'd3
  } seq_state_t;

  localparam logic [31:0] RESET_PC    = 32'h0000_0000;
  localparam int unsigned INSTR_BYTES = 4;

endpackage

// File: rtl/pc_branch_sequencer.sv
// Program-counter owner. Issues IMEM fetch requests and applies branch
// resolutions coming from the EX-stage branch adder.
//
// Handshakes (both valid/ready): a transfer happens in a cycle where valid and
// ready are both high. Once fetch_valid rises, fetch_pc is held until
// fetch_ready, unless a taken branch redirects; stall never retracts a pending
// request. br_ready is high only in RUN, so accept = br_valid & br_ready.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   br_valid/br_ready branch resolution handshake
//   br_target         branch target (adder sum)
//   br_zero           operands-equal flag
//   br_is_bne         1 = BNE (taken on !zero), 0 = BEQ (taken on zero)
//   stall             blocks issue of new fetch requests
//   fetch_valid/fetch_ready/fetch_pc  IMEM request port
//   flush             one-cycle pulse after a taken branch: discard IF/ID
//   misalign_err      sticky: taken branch to a misaligned target
//   taken_cnt         saturating count of accepted taken aligned branches
//   dbg_state         current FSM state (seq_state_t encoding)
module pc_branch_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned     XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_PC    = XLEN'(cpu_pkg::RESET_PC),
  parameter int unsigned     INSTR_BYTES = cpu_pkg::INSTR_BYTES,
  parameter int unsigned     CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             br_valid,
  input  logic [XLEN-1:0]  br_target,
  input  logic             br_zero,
  input  logic             br_is_bne,
  output logic             br_ready,
  input  logic             stall,
  output logic             fetch_valid,
  output logic [XLEN-1:0]  fetch_pc,
  input  logic             fetch_ready,
  output logic             flush,
  output logic             misalign_err,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [1:0]       dbg_state
);

  seq_state_t       state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic             pend_q, pend_d;   // request presented last cycle, not yet accepted
  logic             flush_q, flush_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic taken;
  logic aligned;

  // BEQ taken on zero, BNE taken on !zero.
  assign taken   = br_valid & (br_zero ^ br_is_bne);
  assign aligned = (br_target % XLEN'(INSTR_BYTES)) == '0;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pend_d      = 1'b0;
    flush_d     = 1'b0;
    err_d       = err_q;
    cnt_d       = cnt_q;
    br_ready    = 1'b0;
    fetch_valid = 1'b0;
    case (state_q)
      BOOT:     state_d = RUN;
      RUN: begin
        br_ready    = 1'b1;
        fetch_valid = ~stall | pend_q;
        if (taken) begin
          // Redirect wins over a simultaneous fetch handshake: the fetched
          // instruction is flushed and the pc does not step.
          flush_d = 1'b1;
          if (aligned) begin
            pc_d    = br_target;
            state_d = REDIRECT;
            if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
          end else begin
            err_d   = 1'b1;
            state_d = FAULT;
          end
        end else if (fetch_valid && fetch_ready) begin
          pc_d = pc_q + XLEN'(INSTR_BYTES);
        end else begin
          pend_d = fetch_valid;
        end
      end
      REDIRECT: state_d = RUN;
      FAULT:    state_d = FAULT;
      default:  state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      pend_q  <= 1'b0;
      flush_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      flush_q <= flush_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign fetch_pc     = pc_q;
  assign flush        = flush_q;
  assign misalign_err = err_q;
  assign taken_cnt    = cnt_q;
  assign dbg_state    = state_q;

endmodule
